// File: rtl/key_debounce_pkg.sv
// Shared board constants, FSM state type and key-polarity helper for the
// push-button debouncer.
package key_debounce_pkg;

    localparam int unsigned CLK_FREQ_HZ         = 27_000_000;
    localparam int unsigned DEB_CYCLES_DEFAULT  = CLK_FREQ_HZ / 50;
    localparam int unsigned LONG_CYCLES_DEFAULT = CLK_FREQ_HZ;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_FLT = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_REL_FLT   = 2'd3
    } deb_state_e;

    // Map the raw synchronised pin level to 1 = pressed.
    function automatic logic norm_key(input logic raw, input logic active_low);
        return active_low ? ~raw : raw;
    endfunction

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is
// configurable so the idle pin level survives reset without a false edge.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic I_clk,
    input  logic I_rst_n,
    input  logic I_d,
    output logic O_q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = I_d;
        sync_d = meta_q;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign O_q = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronises the pin, filters level changes for
// DEB_CYCLES stable cycles and emits press / release / long-press pulses.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEB_CYCLES     = DEB_CYCLES_DEFAULT,
    parameter int unsigned LONG_CYCLES    = LONG_CYCLES_DEFAULT,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  logic I_clk,
    input  logic I_rst_n,
    input  logic I_key,
    output logic O_key,
    output logic O_press,
    output logic O_release,
    output logic O_long
);

    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LIMIT  = DEB_W'(DEB_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(LONG_CYCLES);

    if (DEB_CYCLES < 2 || LONG_CYCLES <= DEB_CYCLES) begin : g_param_check
        $error("key_debounce: requires DEB_CYCLES >= 2 and LONG_CYCLES > DEB_CYCLES");
    end

    logic key_sync;
    logic key_s;

    deb_state_e          state_q,     state_d;
    logic [DEB_W-1:0]    deb_cnt_q,   deb_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q,  hold_cnt_d;
    logic                o_key_q,     o_key_d;
    logic                o_press_q,   o_press_d;
    logic                o_release_q, o_release_d;
    logic                o_long_q,    o_long_d;

    logic deb_done;
    logic hold_sat;

    // Released pin level is the reset value so reset never looks like a press.
    sync_2ff #(
        .RST_VAL (KEY_ACTIVE_LOW)
    ) u_sync (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .I_d     (I_key),
        .O_q     (key_sync)
    );

    assign key_s    = norm_key(key_sync, KEY_ACTIVE_LOW);
    assign deb_done = (deb_cnt_q + DEB_W'(1)) == DEB_LIMIT;
    assign hold_sat = (hold_cnt_q == HOLD_LIMIT);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= ST_IDLE;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            o_key_q     <= 1'b0;
            o_press_q   <= 1'b0;
            o_release_q <= 1'b0;
            o_long_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            o_key_q     <= o_key_d;
            o_press_q   <= o_press_d;
            o_release_q <= o_release_d;
            o_long_q    <= o_long_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                hold_cnt_d = '0;
                if (key_s) begin
                    state_d   = ST_PRESS_FLT;
                    deb_cnt_d = DEB_W'(1);
                end else begin
                    deb_cnt_d = '0;
                end
            end
            ST_PRESS_FLT: begin
                if (!key_s) begin
                    state_d   = ST_IDLE;
                    deb_cnt_d = '0;
                end else if (deb_done) begin
                    state_d   = ST_PRESSED;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!hold_sat) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
                if (!key_s) begin
                    state_d   = ST_REL_FLT;
                    deb_cnt_d = DEB_W'(1);
                end
            end
            ST_REL_FLT: begin
                // A bounce back to pressed resumes the hold count where it paused.
                if (key_s) begin
                    state_d   = ST_PRESSED;
                    deb_cnt_d = '0;
                end else if (deb_done) begin
                    state_d    = ST_IDLE;
                    deb_cnt_d  = '0;
                    hold_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                deb_cnt_d  = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        o_key_d     = (state_d == ST_PRESSED) || (state_d == ST_REL_FLT);
        o_press_d   = (state_q == ST_PRESS_FLT) && (state_d == ST_PRESSED);
        o_release_d = (state_q == ST_REL_FLT) && (state_d == ST_IDLE);
        o_long_d    = (state_q == ST_PRESSED) && !hold_sat && (hold_cnt_d == HOLD_LIMIT);
    end

    assign O_key     = o_key_q;
    assign O_press   = o_press_q;
    assign O_release = o_release_q;
    assign O_long    = o_long_q;

endmodule
